// File: rtl/pool_layer_v2.sv
// pool_layer_v2: streaming KxK non-overlapping max/average pooling over row/column/channel-ordered samples.
// Define POOL_RELU_EN to clamp negative pooled results to zero before the output register.
module pool_layer_v2 #(
  parameter int DIN_W = 16,
  parameter int W_IN  = 8,
  parameter int H_IN  = 8,
  parameter int C     = 64,
  parameter int K     = 2,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blob_din_en,
  output logic             blob_din_rdy,
  input  logic [DIN_W-1:0] blob_din,
  input  logic             blob_din_eop,
  output logic             blob_dout_en,
  input  logic             blob_dout_rdy,
  output logic [DIN_W-1:0] blob_dout,
  output logic             blob_dout_eop,
  output logic             frame_err
);
  localparam int W_OUT = W_IN / K;
  localparam int H_OUT = H_IN / K;
  localparam int ACC_W = DIN_W + 4;
  localparam int NENT  = (W_OUT * C > 1) ? W_OUT * C : 2;
  localparam int SH    = (K == 4) ? 4 : 2;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int XW    = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int YW    = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int IW    = $clog2(NENT);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SH - 1));

  logic [CW-1:0]           r_ch;
  logic [XW-1:0]           r_col;
  logic [YW-1:0]           r_row;
  logic                    r_full;
  logic                    r_eop;
  logic                    r_err;
  logic [DIN_W-1:0]        r_dout;
  logic signed [ACC_W-1:0] r_buf [NENT];

  logic                    w_accept;
  logic                    w_frame_last;
  logic                    w_abort;
  logic                    w_in_win;
  logic                    w_first;
  logic                    w_wlast;
  logic                    w_load;
  logic                    w_oeop;
  logic [31:0]             w_col;
  logic [31:0]             w_row;
  logic [31:0]             w_kx;
  logic [31:0]             w_ky;
  logic [31:0]             w_ox;
  logic [31:0]             w_oy;
  logic [31:0]             w_idx;
  logic [IW-1:0]           w_bidx;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_old;
  logic signed [ACC_W-1:0] w_comb;
  logic [DIN_W-1:0]        w_res;
  logic [DIN_W-1:0]        w_out;

  assign blob_din_rdy  = !r_full || blob_dout_rdy;
  assign blob_dout_en  = r_full;
  assign blob_dout     = r_dout;
  assign blob_dout_eop = r_eop;
  assign frame_err     = r_err;

  assign w_accept     = blob_din_en && blob_din_rdy;
  assign w_col        = 32'(r_col);
  assign w_row        = 32'(r_row);
  assign w_kx         = w_col % K;
  assign w_ky         = w_row % K;
  assign w_ox         = w_col / K;
  assign w_oy         = w_row / K;
  assign w_idx        = w_ox * C + 32'(r_ch);
  assign w_in_win     = (w_ox < W_OUT) && (w_oy < H_OUT);
  assign w_first      = (w_kx == 0) && (w_ky == 0);
  assign w_wlast      = (w_kx == K - 1) && (w_ky == K - 1);
  assign w_frame_last = (r_ch == CW'(C - 1)) && (r_col == XW'(W_IN - 1)) && (r_row == YW'(H_IN - 1));
  // An early eop aborts the frame: that sample neither updates the buffer nor emits a result.
  assign w_abort      = blob_din_eop && !w_frame_last;
  assign w_load       = w_accept && w_in_win && w_wlast && !w_abort;
  assign w_oeop       = (w_ox == W_OUT - 1) && (w_oy == H_OUT - 1) && (r_ch == CW'(C - 1));
  assign w_bidx       = w_in_win ? IW'(w_idx) : '0;
  assign w_x          = ACC_W'($signed(blob_din));
  assign w_old        = r_buf[w_bidx];

  always_comb begin
    w_comb = w_x;
    if (!w_first) begin
      if (MODE == 0) w_comb = (w_x > w_old) ? w_x : w_old;
      else           w_comb = w_old + w_x;
    end
  end

  always_comb begin
    if (MODE == 0) w_res = DIN_W'(w_comb);
    else           w_res = DIN_W'((w_comb + RND) >>> SH);
`ifdef POOL_RELU_EN
    w_out = w_res[DIN_W-1] ? '0 : w_res;
`else
    w_out = w_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_in_win && !w_wlast && !w_abort) r_buf[w_bidx] <= w_comb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && (blob_din_eop != w_frame_last);
      if (w_accept) begin
        if (w_abort || w_frame_last) begin
          r_ch  <= '0;
          r_col <= '0;
          r_row <= '0;
        end else if (r_ch != CW'(C - 1)) begin
          r_ch <= r_ch + 1'b1;
        end else begin
          r_ch <= '0;
          if (r_col != XW'(W_IN - 1)) begin
            r_col <= r_col + 1'b1;
          end else begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_dout <= '0;
      r_eop  <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_dout <= w_out;
      r_eop  <= w_oeop;
    end else if (r_full && blob_dout_rdy) begin
      r_full <= 1'b0;
      r_eop  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pool_layer_v2.sv
// Bench for pool_layer_v2: four configurations driven one at a time, scoreboard of expected pooled samples.
module tb_pool_layer_v2;
  localparam int NI = 4;

  typedef struct {
    int inst;
    int data;
    bit eop;
  } exp_t;
  typedef int iq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NI-1:0]       din_en, din_rdy, din_eop, dout_en, dout_rdy, dout_eop, ferr;
  logic signed [15:0]  din  [NI];
  logic signed [15:0]  dout [NI];

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   err_seen [NI];
  int   exp_err  [NI];

  pool_layer_v2 #(.DIN_W(16), .W_IN(4), .H_IN(4), .C(1), .K(2), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .blob_din_en(din_en[0]), .blob_din_rdy(din_rdy[0]), .blob_din(din[0]),
    .blob_din_eop(din_eop[0]), .blob_dout_en(dout_en[0]), .blob_dout_rdy(dout_rdy[0]),
    .blob_dout(dout[0]), .blob_dout_eop(dout_eop[0]), .frame_err(ferr[0]));
  pool_layer_v2 #(.DIN_W(16), .W_IN(4), .H_IN(4), .C(1), .K(2), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .blob_din_en(din_en[1]), .blob_din_rdy(din_rdy[1]), .blob_din(din[1]),
    .blob_din_eop(din_eop[1]), .blob_dout_en(dout_en[1]), .blob_dout_rdy(dout_rdy[1]),
    .blob_dout(dout[1]), .blob_dout_eop(dout_eop[1]), .frame_err(ferr[1]));
  pool_layer_v2 #(.DIN_W(16), .W_IN(7), .H_IN(7), .C(2), .K(3), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .blob_din_en(din_en[2]), .blob_din_rdy(din_rdy[2]), .blob_din(din[2]),
    .blob_din_eop(din_eop[2]), .blob_dout_en(dout_en[2]), .blob_dout_rdy(dout_rdy[2]),
    .blob_dout(dout[2]), .blob_dout_eop(dout_eop[2]), .frame_err(ferr[2]));
  pool_layer_v2 #(.DIN_W(16), .W_IN(8), .H_IN(8), .C(1), .K(4), .MODE(1)) u3 (
    .clk(clk), .rst(rst), .blob_din_en(din_en[3]), .blob_din_rdy(din_rdy[3]), .blob_din(din[3]),
    .blob_din_eop(din_eop[3]), .blob_dout_en(dout_en[3]), .blob_dout_rdy(dout_rdy[3]),
    .blob_dout(dout[3]), .blob_dout_eop(dout_eop[3]), .frame_err(ferr[3]));

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(int inst, int data, bit eop);
    exp_t e;
    e.inst = inst;
    e.data = data;
    e.eop  = eop;
    sb.push_back(e);
  endfunction

  function automatic iq_t rand_frame(int n, int lo, int hi);
    iq_t q;
    for (int j = 0; j < n; j++) q.push_back(lo + int'($urandom_range(hi - lo)));
    return q;
  endfunction

  // Reference pooling over a whole frame: window max or rounded mean, output order out-row, out-col, channel.
  function automatic void model(int inst, int w, int h, int c, int k, int mode, input iq_t s);
    int wo;
    int ho;
    int acc;
    int v;
    wo = w / k;
    ho = h / k;
    for (int oy = 0; oy < ho; oy++)
      for (int ox = 0; ox < wo; ox++)
        for (int ch = 0; ch < c; ch++) begin
          acc = (mode == 0) ? -(1 << 20) : 0;
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              v = s[((oy * k + ky) * w + ox * k + kx) * c + ch];
              if (mode == 0) acc = (v > acc) ? v : acc;
              else           acc = acc + v;
            end
          if (mode == 1) acc = (acc + (k * k) / 2) >>> $clog2(k * k);
`ifdef POOL_RELU_EN
          if (acc < 0) acc = 0;
`endif
          push(inst, acc, (oy == ho - 1) && (ox == wo - 1) && (ch == c - 1));
        end
  endfunction

  task automatic send(input int inst, input int v, input bit e);
    int n;
    n = 0;
    din[inst]     = 16'(v);
    din_eop[inst] = e;
    din_en[inst]  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!din_rdy[inst] && n < 500);
    if (n >= 500) check("din_rdy_timeout", 32'(din_rdy[inst]), 1);
    @(posedge clk);
    #1;
    din_en[inst]  = 1'b0;
    din_eop[inst] = 1'b0;
  endtask

  task automatic send_frame(input int inst, input iq_t s, input bit last_eop, input int abort_at);
    bit e;
    for (int n = 0; n < s.size(); n++) begin
      e = (n == s.size() - 1) ? last_eop : 1'b0;
      if (n == abort_at) e = 1'b1;
      send(inst, s[n], e);
      if (n == abort_at) break;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (ferr[i]) err_seen[i]++;
        if (dout_en[i] && dout_rdy[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_inst", i, e.inst);
            check("out_data", dout[i], e.data);
            check("out_eop", 32'(dout_eop[i]), 32'(e.eop));
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    iq_t s;
    rst      = 1'b0;
    din_en   = '0;
    din_eop  = '0;
    dout_rdy = '1;
    for (int i = 0; i < NI; i++) din[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_dout_en", 32'(dout_en[i]), 0);
      check("rst_dout_eop", 32'(dout_eop[i]), 0);
      check("rst_dout", dout[i], 0);
      check("rst_frame_err", 32'(ferr[i]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("rst_din_rdy", 32'(din_rdy[i]), 1);
    @(posedge clk);
    #1;

    // Raster ramp, 2x2 max
    s.delete();
    for (int j = 0; j < 16; j++) s.push_back(j);
    push(0, 5, 0);
    push(0, 7, 0);
    push(0, 13, 0);
    push(0, 15, 1);
    send_frame(0, s, 1'b1, -1);
    drain("drain_ramp");

    // 2x2 average with known windows plus random fill
    s = rand_frame(16, -300, 300);
    s[0] = 1;  s[1] = 2;  s[4] = 3;  s[5] = 4;
    s[2] = -1; s[3] = -2; s[6] = -3; s[7] = -4;
    model(1, 4, 4, 1, 2, 1, s);
    send_frame(1, s, 1'b1, -1);
    drain("drain_avg");

    // K=3 on 7x7x2: trailing column and row discarded
    s = rand_frame(98, -1000, 1000);
    model(2, 7, 7, 2, 3, 0, s);
    send_frame(2, s, 1'b1, -1);
    drain("drain_k3");

    // Final sample without eop
    s = rand_frame(16, -1000, 1000);
    model(0, 4, 4, 1, 2, 0, s);
    exp_err[0]++;
    send_frame(0, s, 1'b0, -1);
    drain("drain_no_eop");

    // Downstream stall for 20 cycles with an output pending
    s = rand_frame(16, -1000, 1000);
    model(0, 4, 4, 1, 2, 0, s);
    fork
      send_frame(0, s, 1'b1, -1);
      begin
        repeat (3) @(posedge clk);
        #1 dout_rdy[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_dout_en", 32'(dout_en[0]), 1);
        check("stall_din_rdy", 32'(din_rdy[0]), 0);
        @(posedge clk);
        #1 dout_rdy[0] = 1'b1;
      end
    join
    drain("drain_stall");

    // Early eop on sample 10 of 64, then a clean frame (K=4 average)
    s = rand_frame(64, -1000, 1000);
    exp_err[3]++;
    send_frame(3, s, 1'b1, 10);
    s = rand_frame(64, -1000, 1000);
    model(3, 8, 8, 1, 4, 1, s);
    send_frame(3, s, 1'b1, -1);
    drain("drain_abort");

    // All-negative frames
    s = rand_frame(16, -900, -1);
    model(0, 4, 4, 1, 2, 0, s);
    send_frame(0, s, 1'b1, -1);
    drain("drain_neg_k2");
    s = rand_frame(98, -900, -1);
    model(2, 7, 7, 2, 3, 0, s);
    send_frame(2, s, 1'b1, -1);
    drain("drain_neg_k3");

    for (int i = 0; i < NI; i++) begin
      check("frame_err_count", err_seen[i], exp_err[i]);
      check("idle_dout_en", 32'(dout_en[i]), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
